// File: rtl/morse_sequencer_pkg.sv
// morse_sequencer_pkg: shared FSM encoding and letter constants for the morse front end
package morse_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, MARK = 2'd1, SPACE = 2'd2, GAP = 2'd3} state_t;
  localparam int MORSE_MAX_SYM = 5;
  localparam logic DOT = 1'b0;
  localparam logic DASH = 1'b1;
endpackage

// File: rtl/morse_debounce.sv
// morse_debounce: two-flop synchronizer plus a filter that needs DEBOUNCE equal samples to switch
module morse_debounce #(
  parameter int DEBOUNCE = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic m_f
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  logic s1, s2;
  logic [DW-1:0] cnt;
  // synchronize, then flip m_f once the new level has been seen DEBOUNCE times in a row
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      m_f <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == m_f) cnt <= '0;
      else if (cnt == DW'(DEBOUNCE - 1)) begin
        m_f <= s2;
        cnt <= '0;
      end else cnt <= cnt + DW'(1);
    end
  end
endmodule

// File: rtl/morse_sequencer.sv
// morse_sequencer: times marks and spaces on the filtered key and hands finished letters to the processor
module morse_sequencer
  import morse_sequencer_pkg::*;
#(
  parameter int DEBOUNCE   = 2,
  parameter int DASH_MIN   = 60,
  parameter int LETTER_GAP = 150,
  parameter int END_GAP    = 600,
  parameter int CNT_W      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       morse,
  input  logic       sym_ready,
  output logic       sym_valid,
  output logic [4:0] sym_code,
  output logic [2:0] sym_len,
  output logic       sym_err,
  output logic       overrun,
  output logic       decode_end,
  output logic       busy
);
  state_t state, state_d;
  logic m_f, letter_done, msg_end, elem;
  logic [CNT_W-1:0] mark_cnt, space_cnt, mark_inc, space_inc;
  logic [4:0] a_code;
  logic [2:0] a_len;
  logic a_err;
  morse_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clock (clock),
    .reset (reset),
    .din   (morse),
    .m_f   (m_f)
  );
  assign mark_inc  = &mark_cnt ? mark_cnt : mark_cnt + CNT_W'(1);
  assign space_inc = &space_cnt ? space_cnt : space_cnt + CNT_W'(1);
  assign elem      = (mark_cnt >= CNT_W'(DASH_MIN)) ? DASH : DOT;
  assign busy      = state != IDLE;
  // next state; a letter closes or the message ends on the cycle the space count reaches its gap
  always_comb begin
    state_d     = state;
    letter_done = 1'b0;
    msg_end     = 1'b0;
    case (state)
      IDLE:  state_d = m_f ? MARK : IDLE;
      MARK:  state_d = m_f ? MARK : SPACE;
      SPACE: begin
        letter_done = !m_f && space_inc == CNT_W'(LETTER_GAP);
        state_d     = m_f ? MARK : letter_done ? GAP : SPACE;
      end
      default: begin
        msg_end = !m_f && space_inc == CNT_W'(END_GAP);
        state_d = m_f ? MARK : msg_end ? IDLE : GAP;
      end
    endcase
  end
  // state, duration counters and per-letter element assembly
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mark_cnt   <= '0;
      space_cnt  <= '0;
      a_code     <= '0;
      a_len      <= '0;
      a_err      <= 1'b0;
      decode_end <= 1'b0;
    end else begin
      state      <= state_d;
      decode_end <= msg_end;
      mark_cnt   <= (state == MARK) ? mark_inc : CNT_W'(1);
      space_cnt  <= (state == SPACE || state == GAP) ? space_inc : '0;
      if (state_d == MARK && (state == IDLE || state == GAP)) begin
        a_code <= '0;
        a_len  <= '0;
        a_err  <= 1'b0;
      end else if (state == MARK && !m_f) begin
        if (a_len < 3'(MORSE_MAX_SYM)) begin
          a_code <= a_code | (5'(elem) << a_len);
          a_len  <= a_len + 3'd1;
        end else a_err <= 1'b1;
      end
    end
  end
  // one-entry letter buffer; a letter finishing while it is still held is dropped and flagged
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sym_valid <= 1'b0;
      sym_code  <= '0;
      sym_len   <= '0;
      sym_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (letter_done && (!sym_valid || sym_ready)) begin
        sym_valid <= 1'b1;
        sym_code  <= a_code;
        sym_len   <= a_len;
        sym_err   <= a_err;
      end else if (sym_ready) sym_valid <= 1'b0;
      overrun <= overrun | (letter_done & sym_valid & ~sym_ready);
    end
  end
endmodule

// File: tb/tb_morse_sequencer.sv
// tb_morse_sequencer: random and directed key traffic checked against a run-length model of the decoder
module tb_morse_sequencer;
  localparam int DM = 8, LG = 20, EG = 60;
  logic clk = 1'b0, rst_n = 1'b0, morse = 1'b0, sym_ready = 1'b1, morse2 = 1'b0;
  logic sym_valid, sym_err, overrun, decode_end, busy;
  logic [4:0] sym_code;
  logic [2:0] sym_len;
  logic sat_valid, sat_err, sat_ovr, sat_end, sat_busy;
  logic [4:0] sat_code;
  logic [2:0] sat_len;
  int n_cmp = 0, n_bad = 0;
  logic model_en = 1'b1, rand_rdy = 1'b0;
  logic [3:0] q;
  logic high, active, bv, ovr, dend, err, berr;
  int hi, lo, nel;
  logic [4:0] code, bcode;
  logic [2:0] blen;
  int t_valid, t_end, n_end;
  logic [4:0] w_code;
  logic [2:0] w_len;
  logic w_err;

  morse_sequencer #(.DEBOUNCE(2), .DASH_MIN(DM), .LETTER_GAP(LG), .END_GAP(EG), .CNT_W(16)) u_dut (
    .clock(clk), .reset(rst_n), .morse(morse), .sym_ready(sym_ready), .sym_valid(sym_valid),
    .sym_code(sym_code), .sym_len(sym_len), .sym_err(sym_err), .overrun(overrun),
    .decode_end(decode_end), .busy(busy));

  morse_sequencer #(.DEBOUNCE(2), .DASH_MIN(8), .LETTER_GAP(12), .END_GAP(14), .CNT_W(4)) u_sat (
    .clock(clk), .reset(rst_n), .morse(morse2), .sym_ready(1'b1), .sym_valid(sat_valid),
    .sym_code(sat_code), .sym_len(sat_len), .sym_err(sat_err), .overrun(sat_ovr),
    .decode_end(sat_end), .busy(sat_busy));

  always #10 clk = ~clk;

  initial begin
    #1900000;
    $display("FAIL watchdog: simulation did not finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    q = '0; high = 0; active = 0; bv = 0; ovr = 0; dend = 0; err = 0; berr = 0;
    hi = 0; lo = 0; nel = 0; code = '0; bcode = '0; blen = '0;
  endtask

  // line seen by the decoder is the key delayed four cycles; letters are built from run lengths
  task automatic model_step(input logic m, input logic r);
    logic lf, done;
    lf = q[3];
    q = {q[2:0], m};
    dend = 0;
    done = 0;
    if (lf) begin
      if (!high) begin
        if (!active || lo >= LG) begin code = '0; nel = 0; err = 0; end
        high = 1; hi = 0; active = 1;
      end
      hi++;
    end else if (high) begin
      high = 0;
      if (nel < 5) begin code[nel] = (hi >= DM); nel++; end
      else err = 1;
      lo = 0;
    end else if (active) begin
      lo++;
      if (lo == LG) done = 1;
      if (lo == EG) begin dend = 1; active = 0; end
    end
    if (done && (!bv || r)) begin
      bv = 1; bcode = code; blen = 3'(nel); berr = err;
    end else begin
      if (done) ovr = 1;
      if (bv && r) bv = 0;
    end
  endtask

  // every cycle: advance the model with the inputs seen at this edge, then compare just after it
  always @(posedge clk) begin
    if (!rst_n || !model_en) model_clear();
    else begin
      model_step(morse, sym_ready);
      #1;
      chk("cycle", {19'd0, sym_valid, overrun, decode_end, busy, sym_valid ? {sym_code, sym_len, sym_err} : 9'd0},
          {19'd0, bv, ovr, dend, active, bv ? {bcode, blen, berr} : 9'd0});
    end
  end

  task automatic hold(input logic v, input int n);
    morse = v;
    for (int i = 0; i < n; i++) begin
      if (rand_rdy) sym_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
  endtask

  task automatic watch(input int max);
    t_valid = -1; t_end = -1; n_end = 0; morse = 0;
    w_code = 'x; w_len = 'x; w_err = 'x;
    for (int n = 1; n <= max; n++) begin
      @(posedge clk);
      #1;
      if (sym_valid && t_valid < 0) begin
        t_valid = n; w_code = sym_code; w_len = sym_len; w_err = sym_err;
      end
      if (decode_end) begin
        n_end++;
        if (t_end < 0) t_end = n;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max);
    for (int n = 0; n < max && busy; n++) @(negedge clk);
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ne;
    logic got;
    logic [4:0] c;
    logic [2:0] l;
    logic e, quiet;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {20'd0, sym_valid, sym_code, sym_len, sym_err, overrun, decode_end, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    hold(1'b1, 4); hold(1'b0, 4); hold(1'b1, 12);
    watch(80);
    chk("A_valid_time", t_valid, 25);
    chk("A_code", {27'd0, w_code}, 32'b00010);
    chk("A_len", {29'd0, w_len}, 32'd2);
    chk("A_err", {31'd0, w_err}, 32'd0);
    chk("A_end_time", t_end, 65);
    chk("A_end_pulses", n_end, 1);
    chk("A_busy_after", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      hold(1'b1, 4);
      if (i < 5) hold(1'b0, 4);
    end
    watch(80);
    chk("six_code", {27'd0, w_code}, 32'd0);
    chk("six_len", {29'd0, w_len}, 32'd5);
    chk("six_err", {31'd0, w_err}, 32'd1);
    wait_idle(100);

    sym_ready = 1'b0;
    hold(1'b1, 4); hold(1'b0, 30); hold(1'b1, 12);
    watch(40);
    chk("ovr_valid_held", {31'd0, sym_valid}, 32'd1);
    chk("ovr_code_E", {24'd0, sym_code, sym_len}, {24'd0, 5'b00000, 3'd1});
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    sym_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_accept_drop", {31'd0, sym_valid}, 32'd0);
    @(negedge clk);
    wait_idle(100);

    hold(1'b1, 6);
    chk("rst_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {20'd0, sym_valid, sym_code, sym_len, sym_err, overrun, decode_end, busy}, 32'd0);
    morse = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_stays_idle", {31'd0, busy}, 32'd0);
    hold(1'b1, 4);
    watch(80);
    chk("rst_dot_code", {24'd0, w_code, w_len}, {24'd0, 5'b00000, 3'd1});

    model_en = 1'b0;
    morse = 1'b1;
    @(negedge clk);
    morse = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      quiet &= !u_dut.m_f && !busy && !sym_valid && !decode_end;
    end
    chk("glitch_quiet", {31'd0, quiet}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    morse2 = 1'b1;
    repeat (40) @(negedge clk);
    chk("sat_count", {28'd0, u_sat.mark_cnt}, 32'd15);
    morse2 = 1'b0;
    got = 0; c = '0; l = '0; e = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(posedge clk);
      #1;
      if (sat_valid) begin got = 1; c = sat_code; l = sat_len; e = sat_err; end
    end
    chk("sat_seen", {31'd0, got}, 32'd1);
    chk("sat_letter", {23'd0, c, l, e}, {23'd0, 5'b00001, 3'd1, 1'b0});
    chk("sat_side", {29'd0, sat_ovr, sat_end, sat_busy}, 32'd1);
    @(negedge clk);

    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ne = $urandom_range(1, 6);
      for (int j = 0; j < ne; j++) begin
        hold(1'b1, $urandom_range(2, 14));
        if (j < ne - 1) hold(1'b0, $urandom_range(2, 19));
      end
      case ($urandom_range(0, 3))
        0: hold(1'b0, $urandom_range(20, 40));
        1: hold(1'b0, $urandom_range(41, 59));
        2: hold(1'b0, $urandom_range(61, 90));
        default: hold(1'b0, $urandom_range(19, 22));
      endcase
    end
    hold(1'b0, 150);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
